// File: rtl/fp_accum_ctrl.sv
// Accumulator controller wrapped around an external combinational FP adder.
// It streams samples in, feeds the running sum back to the adder, and presents the total on a handshake.
module fp_accum_ctrl #(
   parameter int unsigned CW     = 8,
   parameter int unsigned SETTLE = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          in_valid,
   input  logic [31:0]   in_data,
   output logic          in_ready,
   output logic [31:0]   add_op1,
   output logic [31:0]   add_op2,
   input  logic [31:0]   add_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   acc_out,
   output logic [CW-1:0] acc_count,
   output logic          acc_overflow,
   output logic          busy
);

   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] len_q, len_nxt;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic [31:0]   acc_nxt, op1_nxt, op2_nxt;
   logic [CW-1:0] cnt_nxt, cnt_inc;
   logic          ovf_nxt;
   logic          bypass;

   assign cnt_inc = acc_count + CW'(1);

   // Next-state and datapath update
   always_comb begin
      state_nxt  = state;
      len_nxt    = len_q;
      settle_nxt = settle_cnt;
      acc_nxt    = acc_out;
      cnt_nxt    = acc_count;
      ovf_nxt    = acc_overflow;
      op1_nxt    = add_op1;
      op2_nxt    = add_op2;
      bypass     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               len_nxt   = len;
               acc_nxt   = 32'h0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = (len == '0) ? S_DONE : S_ACCEPT;
            end
         end

         S_ACCEPT: begin
            if (in_valid) begin
               if (in_data[30:0] == 31'h0) begin
                  bypass  = 1'b1;
                  cnt_nxt = cnt_inc;
               end else if (in_data[30:23] == 8'hFF) begin
                  bypass  = 1'b1;
                  ovf_nxt = 1'b1;
                  cnt_nxt = cnt_inc;
               end else if (acc_out[30:0] == 31'h0) begin
                  bypass  = 1'b1;
                  acc_nxt = in_data;
                  cnt_nxt = cnt_inc;
               end else begin
                  op1_nxt    = in_data;
                  op2_nxt    = acc_out;
                  settle_nxt = SW'(SETTLE - 1);
                  state_nxt  = S_WAIT;
               end
               if (bypass) begin
                  state_nxt = (cnt_nxt == len_q) ? S_DONE : S_ACCEPT;
               end
            end
         end

         // Operands stay stable until the adder output has settled
         S_WAIT: begin
            if (settle_cnt != '0) begin
               settle_nxt = settle_cnt - SW'(1);
            end else begin
               acc_nxt = (add_result[30:0] == 31'h0) ? 32'h0 : add_result;
               if (add_result[30:23] == 8'hFF) begin
                  ovf_nxt = 1'b1;
               end
               cnt_nxt   = cnt_inc;
               state_nxt = (cnt_inc == len_q) ? S_DONE : S_ACCEPT;
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs; handshake flags decode the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         len_q        <= '0;
         settle_cnt   <= '0;
         acc_out      <= 32'h0;
         acc_count    <= '0;
         acc_overflow <= 1'b0;
         add_op1      <= 32'h0;
         add_op2      <= 32'h0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         len_q        <= len_nxt;
         settle_cnt   <= settle_nxt;
         acc_out      <= acc_nxt;
         acc_count    <= cnt_nxt;
         acc_overflow <= ovf_nxt;
         add_op1      <= op1_nxt;
         add_op2      <= op2_nxt;
         in_ready     <= (state_nxt == S_ACCEPT);
         out_valid    <= (state_nxt == S_DONE);
         busy         <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Bench for fp_accum_ctrl: a behavioural adder closes the loop, and run results flow through a scoreboard queue.
module tb_fp_accum_ctrl;

   localparam int unsigned CW     = 8;
   localparam int unsigned SETTLE = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] len;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic [31:0]   add_op1, add_op2, add_result;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   acc_out;
   logic [CW-1:0] acc_count;
   logic          acc_overflow;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int wait_cyc = 0;
   int hs_cnt   = 0;

   typedef struct {
      int unsigned     len;
      logic [4:0][31:0] s;
      logic [31:0]     acc;
      bit              ovf;
      int unsigned     adds;
      bit              no_stall;
   } vec_t;

   typedef struct {
      logic [31:0]   acc;
      logic [CW-1:0] cnt;
      bit            ovf;
   } exp_t;

   vec_t vecs[8];
   int   nv = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   // Truncating single-precision adder, enough for exactly representable test sums
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [24:0] mx, my, s;
      int ex, ey;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      if (x[30:23] == 8'hFF) return x;
      if (y[30:0] == 31'h0) return x;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = {2'b01, x[22:0]};
      my = (ex - ey > 24) ? 25'h0 : ({2'b01, y[22:0]} >> (ex - ey));
      if (x[31] == y[31]) begin
         s = mx + my;
         if (s[24]) begin s = s >> 1; ex++; end
      end else begin
         s = mx - my;
         if (s == 25'h0) return 32'h8000_0000;
         while (!s[23]) begin s = s << 1; ex--; end
      end
      if (ex >= 255) return {x[31], 8'hFF, 23'h0};
      if (ex <= 0) return {x[31], 31'h0};
      return {x[31], 8'(ex), s[22:0]};
   endfunction

   assign add_result = fadd(add_op1, add_op2);

   fp_accum_ctrl #(.CW(CW), .SETTLE(SETTLE)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .len          (len),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .add_op1      (add_op1),
      .add_op2      (add_op2),
      .add_result   (add_result),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .acc_out      (acc_out),
      .acc_count    (acc_count),
      .acc_overflow (acc_overflow),
      .busy         (busy)
   );

   // WAIT is the only busy state with neither handshake flag raised
   always @(negedge clk) if (busy && !in_ready && !out_valid) wait_cyc++;
   always @(posedge clk) if (in_valid && in_ready) hs_cnt++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int unsigned l, input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] s3, input logic [31:0] s4,
                          input logic [31:0] acc, input bit ovf, input int unsigned adds,
                          input bit no_stall);
      vecs[nv].len      = l;
      vecs[nv].s[0]     = s0;
      vecs[nv].s[1]     = s1;
      vecs[nv].s[2]     = s2;
      vecs[nv].s[3]     = s3;
      vecs[nv].s[4]     = s4;
      vecs[nv].acc      = acc;
      vecs[nv].ovf      = ovf;
      vecs[nv].adds     = adds;
      vecs[nv].no_stall = no_stall;
      nv++;
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge
   task automatic send(input logic [31:0] d, output int stalls);
      stalls   = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && stalls < 200) begin
         @(negedge clk);
         stalls++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stayed %b for data %h", in_ready, d);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [CW-1:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int   t = 0;
      exp_t e;
      while (!out_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
      e = sb.pop_front();
      chk({name, "_acc"}, acc_out, e.acc);
      chk({name, "_cnt"}, 32'(acc_count), 32'(e.cnt));
      chk({name, "_ovf"}, 32'(acc_overflow), 32'(e.ovf));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_drop_valid"}, 32'(out_valid), 32'd0);
      chk({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic run_vec(input int k);
      vec_t v;
      int   w0, h0, st;
      string name;
      v    = vecs[k];
      w0   = wait_cyc;
      h0   = hs_cnt;
      name = $sformatf("vec%0d", k);
      sb.push_back('{acc: v.acc, cnt: CW'(v.len), ovf: v.ovf});
      pulse_start(CW'(v.len));
      for (int i = 0; i < int'(v.len); i++) begin
         if (!v.no_stall) repeat ($urandom_range(0, 2)) @(negedge clk);
         send(v.s[i], st);
         if (v.no_stall) chk({name, "_ready_stall"}, 32'(st), 32'd0);
      end
      wait_done(name);
      chk({name, "_wait_cycles"}, 32'(wait_cyc - w0), 32'(v.adds * SETTLE));
      chk({name, "_handshakes"}, 32'(hs_cnt - h0), 32'(v.len));
   endtask

   initial begin
      int st;
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;

      // len, samples, expected sum, overflow, adder ops, zero-stall feed
      add_vec(3, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0, 32'h0, 32'h40600000, 1'b0, 2, 1'b0);
      add_vec(4, 32'h00000000, 32'h80000000, 32'h3FC00000, 32'h0, 32'h0, 32'h3FC00000, 1'b0, 0, 1'b1);
      add_vec(2, 32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h7F800000, 1'b1, 1, 1'b0);
      add_vec(1, 32'h7F800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b1, 0, 1'b0);
      add_vec(2, 32'h3F800000, 32'h7FC00000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 1'b1, 0, 1'b0);
      add_vec(2, 32'h3F800000, 32'hBF800000, 32'h0, 32'h0, 32'h0, 32'h00000000, 1'b0, 1, 1'b0);
      add_vec(5, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              32'h40A00000, 1'b0, 4, 1'b0);
      add_vec(3, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 1'b0, 1, 1'b0);

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_acc", acc_out, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Reset asserted while the first adder operation is settling
      pulse_start(CW'(3));
      send(32'h3F800000, st);
      in_valid = 1'b1;
      in_data  = 32'h40000000;
      @(negedge clk);
      in_valid = 1'b0;
      chk("midwait_op1", add_op1, 32'h40000000);
      chk("midwait_op2", add_op2, 32'h3F800000);
      chk("midwait_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_acc", acc_out, 32'h0);
      chk("midrst_cnt", 32'(acc_count), 32'd0);
      chk("midrst_op1", add_op1, 32'h0);
      chk("midrst_op2", add_op2, 32'h0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < nv; k++) run_vec(k);

      // Empty run: done immediately, held under back-pressure, start ignored
      pulse_start(CW'(0));
      chk("len0_out_valid", 32'(out_valid), 32'd1);
      chk("len0_acc", acc_out, 32'h0);
      chk("len0_cnt", 32'(acc_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len   = CW'(7);
         @(negedge clk);
         chk($sformatf("len0_hold%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("len0_hold%0d_cnt", i), 32'(acc_count), 32'd0);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
      chk("start_and_ready_valid", 32'(out_valid), 32'd0);
      chk("start_and_ready_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("start_dropped_busy", 32'(busy), 32'd0);

      // A clean run after everything above
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exceeded, bad=%0d", bad);
      $fatal(1);
   end

endmodule
